// File: rtl/note_draw_scheduler.sv
// Per-frame sequencer for the note-block plotter: erases last frame's blocks from a
// shadow copy of the rows, then fetches and draws the current rows lane by lane.
module note_draw_scheduler #(
   parameter int ROWS  = 8,
   parameter int LANES = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_start,
   input  logic       pause,
   output logic [2:0] row_addr,
   input  logic [4:0] row_data,
   output logic       plot_note,
   output logic       clear_note,
   output logic       enable_plotter,
   output logic [8:0] x_to_plotter,
   output logic [7:0] y_to_plotter,
   output logic [2:0] lane_id,
   input  logic       plotter_done,
   output logic       busy,
   output logic       frame_done
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_ERASE_SCAN = 3'd1;
   localparam logic [2:0] S_ERASE_WAIT = 3'd2;
   localparam logic [2:0] S_FETCH      = 3'd3;
   localparam logic [2:0] S_LATCH      = 3'd4;
   localparam logic [2:0] S_DRAW_SCAN  = 3'd5;
   localparam logic [2:0] S_DRAW_WAIT  = 3'd6;
   localparam logic [2:0] S_DONE       = 3'd7;

   localparam logic [2:0] LAST_LANE = 3'(LANES);
   localparam logic [2:0] LAST_ROW  = 3'(ROWS - 1);

   logic [2:0] state;
   logic [2:0] row;
   logic [2:0] lane;
   logic [4:0] cur;
   logic [4:0] shadow [ROWS];

   logic       erase_pass;
   logic       last_lane;
   logic       last_row;
   logic [4:0] lane_mask;
   logic [4:0] scan_bits;
   logic       bit_set;
   logic [2:0] adv_lane;
   logic [2:0] adv_row;
   logic [2:0] adv_state;
   logic [8:0] row12;
   logic [8:0] row6;
   logic [8:0] x_next;
   logic [7:0] y_next;

   assign last_lane = (lane == LAST_LANE);
   assign last_row  = (row == LAST_ROW);
   assign lane_mask = 5'b00001 << (lane - 3'd1);

   // Which row word is being scanned depends on the pass: shadow while erasing, cur while drawing.
   always_comb begin
      erase_pass = (state == S_ERASE_SCAN) || (state == S_ERASE_WAIT);
      scan_bits  = erase_pass ? shadow[row] : cur;
      bit_set    = |(scan_bits & lane_mask);
   end

   // Where the FSM goes once the current lane is finished, whether it was empty or plotted.
   always_comb begin
      adv_lane  = last_lane ? 3'd1 : lane + 3'd1;
      adv_row   = row;
      adv_state = erase_pass ? S_ERASE_SCAN : S_DRAW_SCAN;
      if (last_lane) begin
         adv_row = last_row ? 3'd0 : row + 3'd1;
         if (erase_pass) begin
            adv_state = last_row ? S_FETCH : S_ERASE_SCAN;
         end else begin
            adv_state = last_row ? S_DONE : S_FETCH;
         end
      end
   end

   // Perspective fan-out: outer lanes spread by 12 px per row, inner lanes by 6, rows 26 px apart.
   always_comb begin
      row12  = {3'b000, row, 3'b000} + {4'b0000, row, 2'b00};
      row6   = {4'b0000, row, 2'b00} + {5'b00000, row, 1'b0};
      y_next = 8'd40 + {1'b0, row, 4'b0000} + {2'b00, row, 3'b000} + {4'b0000, row, 1'b0};
      case (lane)
         3'd1:    x_next = 9'd130 - row12;
         3'd2:    x_next = 9'd145 - row6;
         3'd3:    x_next = 9'd160;
         3'd4:    x_next = 9'd175 + row6;
         3'd5:    x_next = 9'd190 + row12;
         default: x_next = 9'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= S_IDLE;
         row          <= 3'd0;
         lane         <= 3'd1;
         cur          <= 5'd0;
         x_to_plotter <= 9'd0;
         y_to_plotter <= 8'd0;
         lane_id      <= 3'd0;
         for (int i = 0; i < ROWS; i++) begin
            shadow[i] <= 5'd0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (frame_start) begin
                  state <= S_ERASE_SCAN;
                  row   <= 3'd0;
                  lane  <= 3'd1;
               end
            end
            S_ERASE_SCAN, S_DRAW_SCAN: begin
               if (!pause) begin
                  if (bit_set) begin
                     state        <= erase_pass ? S_ERASE_WAIT : S_DRAW_WAIT;
                     x_to_plotter <= x_next;
                     y_to_plotter <= y_next;
                     lane_id      <= lane;
                  end else begin
                     state <= adv_state;
                     row   <= adv_row;
                     lane  <= adv_lane;
                  end
               end
            end
            // pause is deliberately not looked at here: an in-flight request runs to completion
            S_ERASE_WAIT, S_DRAW_WAIT: begin
               if (plotter_done) begin
                  state <= adv_state;
                  row   <= adv_row;
                  lane  <= adv_lane;
               end
            end
            S_FETCH: begin
               if (!pause) begin
                  state <= S_LATCH;
               end
            end
            S_LATCH: begin
               if (!pause) begin
                  cur         <= row_data;
                  shadow[row] <= row_data;
                  state       <= S_DRAW_SCAN;
                  lane        <= 3'd1;
               end
            end
            S_DONE: begin
               if (!pause) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign row_addr       = row;
   assign clear_note     = (state == S_ERASE_WAIT);
   assign plot_note      = (state == S_DRAW_WAIT);
   assign enable_plotter = clear_note | plot_note;
   assign busy           = (state != S_IDLE);
   assign frame_done     = (state == S_DONE) && !pause;

endmodule

// File: tb/tb_note_draw_scheduler.sv
// Self-checking bench for note_draw_scheduler: table vectors, hand-built corner
// sequences and random frames compared against a request-list reference model.
module tb_note_draw_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       frame_start = 1'b0;
   logic       pause = 1'b0;
   logic [2:0] row_addr;
   logic [4:0] row_data = 5'd0;
   logic       plot_note;
   logic       clear_note;
   logic       enable_plotter;
   logic [8:0] x_to_plotter;
   logic [7:0] y_to_plotter;
   logic [2:0] lane_id;
   logic       plotter_done;
   logic       busy;
   logic       frame_done;

   logic resp_done = 1'b0;
   logic spur_done = 1'b0;
   assign plotter_done = resp_done | spur_done;

   logic [7:0][4:0] mem = '0;
   int lat = 0;
   int wcnt = 0;
   int tests = 0;
   int fails = 0;

   typedef struct {
      bit clr;
      int x;
      int y;
      int lane;
   } req_t;

   typedef struct {
      logic [7:0][4:0] rows;
      int lat;
      int exp_reqs;
      int exp_cycles;
   } vec_t;

   req_t exp_q[$];
   req_t got_q[$];
   logic [7:0][4:0] model_shadow = '0;
   vec_t vecs[5];
   int cyc;
   int nr;

   note_draw_scheduler dut (
      .clk(clk), .reset(reset), .frame_start(frame_start), .pause(pause),
      .row_addr(row_addr), .row_data(row_data), .plot_note(plot_note),
      .clear_note(clear_note), .enable_plotter(enable_plotter),
      .x_to_plotter(x_to_plotter), .y_to_plotter(y_to_plotter), .lane_id(lane_id),
      .plotter_done(plotter_done), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Note register file: synchronous read, data valid the cycle after the address.
   always @(posedge clk) row_data <= mem[row_addr];

   // Plotter: done pulses 'lat' cycles after the first cycle of a request.
   always @(negedge clk) begin
      if (enable_plotter) begin
         wcnt = wcnt + 1;
         resp_done = (wcnt == lat + 1);
      end else begin
         wcnt = 0;
         resp_done = 1'b0;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int x_model(input int lane, input int r);
      case (lane)
         1: return 130 - 12 * r;
         2: return 145 - 6 * r;
         3: return 160;
         4: return 175 + 6 * r;
         default: return 190 + 12 * r;
      endcase
   endfunction

   // Expected request list: clears for last frame's rows, then plots for the new ones.
   task automatic build_expected(input logic [7:0][4:0] rows);
      exp_q.delete();
      for (int r = 0; r < 8; r++)
         for (int l = 1; l <= 5; l++)
            if (model_shadow[r][l-1]) exp_q.push_back('{1'b1, x_model(l, r), 26 * r + 40, l});
      for (int r = 0; r < 8; r++)
         for (int l = 1; l <= 5; l++)
            if (rows[r][l-1]) exp_q.push_back('{1'b0, x_model(l, r), 26 * r + 40, l});
      model_shadow = rows;
   endtask

   task automatic applyStimulus(input logic [7:0][4:0] rows, input int latency,
                                input int pause_plot, input int pause_len,
                                input int busy_start, input int spur_at,
                                output int cycles_out, output int nreq_out);
      int n, done_cyc, done_cnt, plots_seen, pcnt, stall, exp_cyc;
      bit pausing, after_done, frozen_ok, overlap_ok, busy_ok, stable_ok, busy_after, prev_en;
      logic [2:0] frozen_addr;
      mem = rows;
      lat = latency;
      build_expected(rows);
      stall = (pause_plot >= 0 && pause_len > latency + 1) ? pause_len - (latency + 1) : 0;
      exp_cyc = 97 + exp_q.size() * (latency + 1) + stall;
      got_q.delete();
      n = 1; done_cyc = -1; done_cnt = 0; plots_seen = 0; pcnt = 0;
      pausing = 0; after_done = 0; frozen_ok = 1; overlap_ok = 1; busy_ok = 1;
      stable_ok = 1; busy_after = 0; prev_en = 0; frozen_addr = 3'd0;
      @(negedge clk) frame_start = 1'b1;
      @(posedge clk);
      @(negedge clk) frame_start = 1'b0;
      while (n <= exp_cyc + 300 && done_cyc < 0) begin
         if (plot_note && clear_note) overlap_ok = 0;
         if (enable_plotter != (plot_note | clear_note)) overlap_ok = 0;
         if (!busy) busy_ok = 0;
         if (pausing) begin
            pcnt++;
            if (pcnt == pause_len) begin
               pause = 1'b0;
               pausing = 0;
            end else if (!enable_plotter && prev_en && !after_done) begin
               after_done = 1;
               frozen_addr = row_addr;
            end else if (after_done && (enable_plotter || row_addr != frozen_addr)) begin
               frozen_ok = 0;
            end
         end
         if (enable_plotter && !prev_en) begin
            got_q.push_back('{clear_note, int'(x_to_plotter), int'(y_to_plotter), int'(lane_id)});
            if (plot_note) begin
               if (plots_seen == pause_plot) begin
                  pause = 1'b1;
                  pausing = 1;
                  pcnt = 0;
               end
               plots_seen++;
            end
         end else if (enable_plotter && got_q.size() > 0) begin
            if (got_q[$].x != int'(x_to_plotter) || got_q[$].y != int'(y_to_plotter) ||
                got_q[$].lane != int'(lane_id) || got_q[$].clr != clear_note) stable_ok = 0;
         end
         if (frame_done) begin
            done_cyc = n;
            done_cnt++;
         end
         frame_start = (n == busy_start);
         spur_done = (n == spur_at);
         prev_en = enable_plotter;
         if (done_cyc < 0) begin
            n++;
            @(negedge clk);
         end
      end
      frame_start = 1'b0;
      spur_done = 1'b0;
      pause = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (frame_done) done_cnt++;
         if (busy) busy_after = 1;
      end
      check("frame_length", done_cyc, exp_cyc);
      check("frame_done_pulses", done_cnt, 1);
      check("busy_during_frame", busy_ok, 1);
      check("idle_after_frame", busy_after, 0);
      check("no_overlap", overlap_ok, 1);
      check("request_stable", stable_ok, 1);
      check("request_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check("req_clear", got_q[i].clr, exp_q[i].clr);
         check("req_x", got_q[i].x, exp_q[i].x);
         check("req_y", got_q[i].y, exp_q[i].y);
         check("req_lane", got_q[i].lane, exp_q[i].lane);
      end
      if (pause_plot >= 0) check("pause_freeze", frozen_ok && after_done, 1);
      cycles_out = done_cyc;
      nreq_out = got_q.size();
   endtask

   task automatic checkOutput(input string tag);
      check({tag, "_row_addr"}, row_addr, 0);
      check({tag, "_plot"}, plot_note, 0);
      check({tag, "_clear"}, clear_note, 0);
      check({tag, "_enable"}, enable_plotter, 0);
      check({tag, "_x"}, x_to_plotter, 0);
      check({tag, "_y"}, y_to_plotter, 0);
      check({tag, "_lane"}, lane_id, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_frame_done"}, frame_done, 0);
   endtask

   initial begin
      int xs[5];
      logic [7:0][4:0] rows;
      bit seen;
      xs = '{46, 103, 160, 217, 274};

      vecs[0] = '{'0, 3, 0, 97};
      vecs[1] = '{'0, 16, 1, 114};
      vecs[1].rows[2] = 5'b00001;
      vecs[2] = '{'0, 16, 1, 114};
      vecs[3] = '{'0, 4, 5, 122};
      vecs[3].rows[7] = 5'b11111;
      vecs[4] = '{'0, 0, 8, 105};
      vecs[4].rows[0] = 5'b10101;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset");
      reset = 1'b1;

      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].rows, vecs[i].lat, -1, 0, 0, 0, cyc, nr);
         check("vec_cycles", cyc, vecs[i].exp_cycles);
         check("vec_requests", nr, vecs[i].exp_reqs);
         if (i == 1 || i == 2) begin
            if (got_q.size() >= 1) begin
               check("row2_clear_flag", got_q[0].clr, (i == 2) ? 1 : 0);
               check("row2_x", got_q[0].x, 106);
               check("row2_y", got_q[0].y, 92);
               check("row2_lane", got_q[0].lane, 1);
            end
         end
         if (i == 3) begin
            for (int k = 0; k < 5 && k < got_q.size(); k++) begin
               check("row7_x", got_q[k].x, xs[k]);
               check("row7_y", got_q[k].y, 222);
               check("row7_lane", got_q[k].lane, k + 1);
            end
         end
      end

      // Pause held through a draw request: 3 clears + 2 plots at 17 cycles, plus 33 stalled.
      rows = '0;
      rows[3] = 5'b00110;
      applyStimulus(rows, 16, 0, 50, 0, 0, cyc, nr);
      check("pause_cycles", cyc, 215);

      // frame_start while busy plus a stray done in an erase scan cycle.
      applyStimulus('0, 2, -1, 0, 20, 5, cyc, nr);
      check("busy_start_cycles", cyc, 103);

      // Reset while a clear is pending.
      rows = '0;
      rows[1] = 5'b01000;
      applyStimulus(rows, 3, -1, 0, 0, 0, cyc, nr);
      mem = '0;
      lat = 30;
      @(negedge clk) frame_start = 1'b1;
      @(posedge clk);
      @(negedge clk) frame_start = 1'b0;
      seen = 0;
      for (int k = 0; k < 100 && !seen; k++) begin
         if (clear_note) seen = 1;
         else @(negedge clk);
      end
      check("erase_wait_reached", seen, 1);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("midframe_reset");
      reset = 1'b1;
      model_shadow = '0;
      applyStimulus('0, 3, -1, 0, 0, 0, cyc, nr);
      check("post_reset_requests", nr, 0);

      for (int k = 0; k < 6; k++) begin
         for (int r = 0; r < 8; r++) rows[r] = 5'($urandom & $urandom & 32'h1f);
         applyStimulus(rows, int'($urandom_range(0, 5)), -1, 0, 0, 0, cyc, nr);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/note_draw_scheduler.md
Name: note_draw_scheduler

Overview:
- Sequences the note-block plotter once per display frame.
- Each frame has two passes:
  - Erase pass: clears every block drawn in the previous frame, taken from an internal shadow copy of the rows.
  - Draw pass: fetches the current note rows from the note register file and plots every set lane.
- Computes per-lane, perspective-correct x/y and performs the plot/clear/enable/done handshake with the plotter.
- Sits between the game FSM (frame_start, pause) and the plotter/VGA path.

Parameters:
- ROWS, 8: number of note rows per frame (row index width 3).
- LANES, 5: lanes per row (bit i-1 of a row word = lane i, lanes 1..5).

Ports:
- clk  input  1  system clock.
- reset  input  1  reset, synchronous, active-low (asserted when 0, sampled on rising clk).
- frame_start  input  1  one-cycle pulse: begin a frame; honoured only in IDLE.
- pause  input  1  hold sequencing (see Behaviour).
- row_addr  output  3  note register file read address.
- row_data  input  5  register file read data, valid the cycle after row_addr is presented.
- plot_note  output  1  plotter draw request.
- clear_note  output  1  plotter erase request.
- enable_plotter  output  1  qualifies plot_note/clear_note.
- x_to_plotter  output  9  block x origin.
- y_to_plotter  output  8  block y origin.
- lane_id  output  3  current lane 1..5 (plotter colour select).
- plotter_done  input  1  one-cycle pulse from the plotter when the 16-pixel block is finished.
- busy  output  1  high in any state except IDLE.
- frame_done  output  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0: row_addr, plot_note, clear_note, enable_plotter, x, y, lane_id, busy, frame_done.
  - Shadow rows are cleared to 0, row counter to 0, lane counter to 1.
  - A reset mid-frame abandons any request immediately; the plotter sees its requests drop the next cycle.
- Coordinates (registered with lane/row; r = row 0..7):
  - y = 26*r + 40.
  - x by lane: lane1 = 130 - 12r, lane2 = 145 - 6r, lane3 = 160, lane4 = 175 + 6r, lane5 = 190 + 12r.
  - All results fit unsigned 9/8 bits; range x 46..274, y 40..222.
- States:
  - IDLE: frame_start -> ERASE_SCAN, with row=0, lane=1.
  - ERASE_SCAN (1 cycle per lane): test shadow[row] bit lane-1.
    - Set: -> ERASE_WAIT.
    - Clear: advance lane.
  - ERASE_WAIT:
    - clear_note=1, enable_plotter=1, x/y/lane_id stable.
    - On plotter_done: drop the request the next cycle and advance lane.
  - Lane advance:
    - lane 1..4 -> lane+1.
    - After lane 5: lane=1, row+1.
    - After row ROWS-1 in the erase pass: row=0 -> FETCH.
  - FETCH: row_addr=row -> LATCH.
  - LATCH: capture row_data into cur and into shadow[row] -> DRAW_SCAN, lane=1.
  - DRAW_SCAN / DRAW_WAIT: same as the erase states, but testing cur and driving plot_note.
    - After lane 5: row+1 -> FETCH.
    - After the last row: -> DONE.
  - DONE: frame_done=1 for one cycle -> IDLE.
- Handshake:
  - plot_note and clear_note are never high together.
  - A request is held until the plotter_done pulse.
  - plotter_done outside a WAIT state is ignored.
  - At least one cycle with enable_plotter=0 separates consecutive requests.
- Pause:
  - In SCAN, FETCH and LATCH states, pause freezes state and counters.
  - In WAIT states, an in-flight request stays asserted until done, then the FSM stalls before the next lane.
  - frame_done is deferred while paused.
- frame_start while busy is ignored (not queued).
- Timing with no set bits anywhere: IDLE->ERASE takes 1 cycle, erase takes 40 cycles, draw takes 8*(2+5)=56 cycles. frame_done is therefore high during the 97th cycle after the edge that sampled frame_start.
- Each set bit adds the cycles spent in WAIT, i.e. (plotter latency to done) + 1.

Test Plan:
- Reset, then all row_data=0, frame_start pulse -> no plot_note/clear_note ever; frame_done high exactly 97 cycles after the sampling edge; busy high throughout.
- Row 2 = 5'b00001, plotter model returns done 16 cycles after request -> one plot_note with x=106, y=92, lane_id=1; next frame with all rows zero -> one clear_note at the same x/y.
- Row 7 = 5'b11111 -> five plot requests in order lane1..5 with x = 46, 103, 160, 217, 274 and y = 222; enable_plotter drops between each.
- pause asserted mid-DRAW_WAIT for 50 cycles -> request held until done, then no new request and row_addr frozen until pause drops; total frame time grows by exactly the stall.
- reset=0 during ERASE_WAIT -> the next cycle shows all outputs 0 and busy=0; a subsequent frame issues no clear (shadow cleared).
- frame_start pulsed while busy -> ignored; exactly one frame_done; spurious plotter_done in SCAN states has no effect.
